// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and types for the sprite plotter
//
// Contents:
//   OP_DRAW / OP_ERASE       operation encoding sampled with start
//   state_t, ST_*            plotter FSM state encoding
//   DEF_FG_COLOR/BG_COLOR    default pixel colours
//   DEF_BITMAP               default 5x5 sprite shape, bit r*5+c
//   cnt_w()                  counter width helper (minimum 1 bit)

package sprite_pkg;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_ERASE = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SCAN   = 2'd1;
    localparam state_t ST_FINISH = 2'd2;

    localparam logic [2:0]  DEF_FG_COLOR = 3'b111;
    localparam logic [2:0]  DEF_BG_COLOR = 3'b000;
    localparam logic [24:0] DEF_BITMAP   = 25'h023B6A;

    // Width needed to count 0..n-1; a single-value counter still gets one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// rtl/sprite_pixel_counter.sv - nested column/row/sprite scan counter
//
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   clear          force all counters to 0 (has priority over enable)
//   enable         advance one pixel this cycle
//   skip           abandon the current sprite: jump to column 0, row 0 of the next
//   col, row, spr  current scan position
//   last_pixel     current position is the final pixel of the pass
//                  (last pixel of the last sprite, or a skipped last sprite)

module sprite_pixel_counter
    import sprite_pkg::*;
#(
    parameter int COLS    = 5,
    parameter int ROWS    = 5,
    parameter int SPRITES = 10,
    localparam int CW = cnt_w(COLS),
    localparam int RW = cnt_w(ROWS),
    localparam int SW = cnt_w(SPRITES)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    input  logic          skip,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [SW-1:0] spr,
    output logic          last_pixel
);

    logic col_last;
    logic row_last;
    logic spr_last;
    logic spr_end;

    assign col_last   = (col == CW'(COLS - 1));
    assign row_last   = (row == RW'(ROWS - 1));
    assign spr_last   = (spr == SW'(SPRITES - 1));
    assign spr_end    = skip || (col_last && row_last);
    assign last_pixel = spr_last && spr_end;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            col <= '0;
            row <= '0;
            spr <= '0;
        end else if (enable) begin
            if (spr_end) begin
                col <= '0;
                row <= '0;
                spr <= spr_last ? '0 : spr + SW'(1);
            end else if (col_last) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - multi-sprite bitmap renderer, one pixel per cycle
//
// Scans NUM_SPRITES sprites of SPR_W x SPR_H pixels (sprite, row, column
// order) and emits registered pixel writes for the frame-buffer writer.
// Optional build macro SPRITE_PLOTTER_SKIP_INVISIBLE_EN: in draw mode an
// invisible sprite costs a single cycle instead of a full sprite scan.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   start                request one pass (accepted only in IDLE)
//   op                   0 = draw, 1 = erase; latched with start
//   x_flat, y_flat       per-sprite top-left coordinates, COORD_W bits each
//   visible              per-sprite visibility; latched with start
//   busy                 pass in progress (pixel output cycles)
//   done                 one-cycle pulse after the last pixel output
//   plot                 pixel write strobe
//   x_out, y_out         pixel coordinates
//   color_out            pixel colour

module sprite_plotter
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 10,
    parameter int SPR_W       = 5,
    parameter int SPR_H       = 5,
    parameter int COORD_W     = 8,
    parameter int COLOR_W     = 3,
    parameter logic [COLOR_W-1:0]     FG_COLOR = DEF_FG_COLOR,
    parameter logic [COLOR_W-1:0]     BG_COLOR = DEF_BG_COLOR,
    parameter logic [SPR_W*SPR_H-1:0] BITMAP   = DEF_BITMAP
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic                           op,
    input  logic [NUM_SPRITES*COORD_W-1:0] x_flat,
    input  logic [NUM_SPRITES*COORD_W-1:0] y_flat,
    input  logic [NUM_SPRITES-1:0]         visible,
    output logic                           busy,
    output logic                           done,
    output logic                           plot,
    output logic [COORD_W-1:0]             x_out,
    output logic [COORD_W-1:0]             y_out,
    output logic [COLOR_W-1:0]             color_out
);

    localparam int CW = cnt_w(SPR_W);
    localparam int RW = cnt_w(SPR_H);
    localparam int SW = cnt_w(NUM_SPRITES);

    state_t state;

    logic [NUM_SPRITES*COORD_W-1:0] x_q, y_q, x_src, y_src;
    logic [NUM_SPRITES-1:0]         vis_q, vis_src;
    logic                           op_q, op_src;

    logic          accept;
    logic          pix_valid;
    logic          cnt_clear;
    logic          skip;
    logic          last_pixel;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [SW-1:0] spr;

    logic [COORD_W-1:0]     x_i, y_i;
    logic                   vis_i;
    logic [COORD_W:0]       sum_x, sum_y;
    logic [SPR_W*SPR_H-1:0] bm_shift;
    logic [COLOR_W-1:0]     color_d;
    logic                   plot_d;

    // Pixel 0 is selected in the accept cycle itself so that it is on the
    // outputs the very next cycle; the latches are not loaded until that
    // edge, so the live inputs feed the datapath while in IDLE.
    assign accept    = (state == ST_IDLE) && start;
    assign pix_valid = accept || (state == ST_SCAN);
    assign cnt_clear = (state != ST_SCAN) && !accept;

    always_comb begin
        x_src   = x_q;
        y_src   = y_q;
        vis_src = vis_q;
        op_src  = op_q;
        if (state == ST_IDLE) begin
            x_src   = x_flat;
            y_src   = y_flat;
            vis_src = visible;
            op_src  = op;
        end
    end

    always_comb begin
        x_i   = '0;
        y_i   = '0;
        vis_i = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (spr == SW'(i)) begin
                x_i   = x_src[i*COORD_W +: COORD_W];
                y_i   = y_src[i*COORD_W +: COORD_W];
                vis_i = vis_src[i];
            end
        end
    end

`ifdef SPRITE_PLOTTER_SKIP_INVISIBLE_EN
    assign skip = pix_valid && (op_src == OP_DRAW) && !vis_i;
`else
    assign skip = 1'b0;
`endif

    sprite_pixel_counter #(
        .COLS    (SPR_W),
        .ROWS    (SPR_H),
        .SPRITES (NUM_SPRITES)
    ) u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .enable     (pix_valid),
        .skip       (skip),
        .col        (col),
        .row        (row),
        .spr        (spr),
        .last_pixel (last_pixel)
    );

    // The extra top bit of each sum is the carry that marks an off-screen pixel.
    always_comb begin
        sum_x    = {1'b0, x_i} + (COORD_W+1)'(col);
        sum_y    = {1'b0, y_i} + (COORD_W+1)'(row);
        bm_shift = BITMAP >> (int'(row) * SPR_W + int'(col));
        if (op_src == OP_ERASE) begin
            color_d = BG_COLOR;
        end else begin
            color_d = bm_shift[0] ? FG_COLOR : BG_COLOR;
        end
        plot_d = pix_valid && (vis_i || (op_src == OP_ERASE)) &&
                 !sum_x[COORD_W] && !sum_y[COORD_W];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            x_q   <= '0;
            y_q   <= '0;
            vis_q <= '0;
            op_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_q   <= x_flat;
                        y_q   <= y_flat;
                        vis_q <= visible;
                        op_q  <= op;
                        state <= last_pixel ? ST_FINISH : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (last_pixel) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            plot      <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
        end else begin
            busy      <= pix_valid;
            done      <= (state == ST_FINISH);
            plot      <= plot_d;
            x_out     <= pix_valid ? sum_x[COORD_W-1:0] : '0;
            y_out     <= pix_valid ? sum_y[COORD_W-1:0] : '0;
            color_out <= pix_valid ? color_d : '0;
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - self-checking bench for sprite_plotter

module tb_sprite_plotter;

    localparam int N   = 10;
    localparam int W   = 5;
    localparam int H   = 5;
    localparam int WIN = 300;
    localparam logic [24:0] BMP = 25'h023B6A;
`ifdef SPRITE_PLOTTER_SKIP_INVISIBLE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [79:0] x_flat = '0;
    logic [79:0] y_flat = '0;
    logic [9:0]  visible = '0;
    logic        busy, done, plot;
    logic [7:0]  x_out, y_out;
    logic [2:0]  color_out;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic        cap_busy [512];
    logic        cap_done [512];
    logic        cap_plot [512];
    logic [18:0] cap_pix  [512];
    logic        exp_plot [512];
    logic [18:0] exp_pix  [512];
    int          exp_len;

    logic [79:0] live_x, live_y;
    logic [9:0]  live_vis;
    logic        live_op;

    sprite_plotter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .x_flat    (x_flat),
        .y_flat    (y_flat),
        .visible   (visible),
        .busy      (busy),
        .done      (done),
        .plot      (plot),
        .x_out     (x_out),
        .y_out     (y_out),
        .color_out (color_out)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] rand_coords(input int lo, input int hi);
        logic [79:0] v;
        for (int s = 0; s < N; s++) v[s*8 +: 8] = 8'($urandom_range(hi, lo));
        return v;
    endfunction

    // Reference: the pass as an ordered list of pixel-output cycles 1..exp_len.
    task automatic build_model(input logic m_op, input logic [9:0] m_vis,
                               input logic [79:0] mx, input logic [79:0] my);
        int k, px, py;
        logic [24:0] bm;
        bm = BMP;
        k = 0;
        for (int i = 0; i < 512; i++) begin
            exp_plot[i] = 1'b0;
            exp_pix[i]  = '0;
        end
        for (int s = 0; s < N; s++) begin
            if (SKIP && !m_op && !m_vis[s]) begin
                k++;
            end else begin
                for (int r = 0; r < H; r++) begin
                    for (int c = 0; c < W; c++) begin
                        k++;
                        px = int'(mx[s*8 +: 8]) + c;
                        py = int'(my[s*8 +: 8]) + r;
                        exp_plot[k] = (m_vis[s] || m_op) && (px < 256) && (py < 256);
                        exp_pix[k]  = {px[7:0], py[7:0], (m_op || !bm[r*W + c]) ? 3'd0 : 3'd7};
                    end
                end
            end
        end
        exp_len = k;
    endtask

    // Starts a pass and records WIN output cycles after acceptance. Live inputs
    // are scrambled right after acceptance so any failure to latch shows up.
    task automatic run_pass(input logic p_op, input logic [9:0] p_vis,
                            input logic [79:0] px, input logic [79:0] py,
                            input bit hold, input int restart_cyc, input int reset_cyc);
        @(negedge clk);
        op = p_op; visible = p_vis; x_flat = px; y_flat = py; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= WIN; k++) begin
            #1;
            if (!hold) start = (k == restart_cyc);
            if (k == 1) begin
                live_x = rand_coords(0, 255); live_y = rand_coords(0, 255);
                live_vis = 10'($urandom); live_op = 1'($urandom);
                x_flat = live_x; y_flat = live_y; visible = live_vis; op = live_op;
            end
            reset_n = (k != reset_cyc);
            @(negedge clk);
            cap_busy[k] = busy; cap_done[k] = done; cap_plot[k] = plot;
            cap_pix[k]  = {x_out, y_out, color_out};
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
        total_cnt++; if (plot !== 1'b0) $display("FAIL reset_plot: got %b want 0", plot); else pass_cnt++;
        total_cnt++; if ({x_out, y_out, color_out} !== 19'd0)
            $display("FAIL reset_pixel: got %h want 0", {x_out, y_out, color_out}); else pass_cnt++;
    endtask

    task automatic test_draw_fixed();
        logic [79:0] xs, ys;
        int bad, first, plots, fd;
        xs = rand_coords(0, 200); ys = rand_coords(0, 200);
        xs[7:0] = 8'd10; ys[7:0] = 8'd20;
        build_model(1'b0, 10'h3FF, xs, ys);
        run_pass(1'b0, 10'h3FF, xs, ys, 1'b0, 0, 0);
        total_cnt++; if (cap_plot[1] !== 1'b1 || cap_pix[1] !== {8'd10, 8'd20, 3'd0})
            $display("FAIL draw_first_pixel: got plot=%b pix=%h want plot=1 pix=%h", cap_plot[1], cap_pix[1], {8'd10, 8'd20, 3'd0}); else pass_cnt++;
        total_cnt++; if (cap_plot[2] !== 1'b1 || cap_pix[2] !== {8'd11, 8'd20, 3'd7})
            $display("FAIL draw_second_pixel: got plot=%b pix=%h want plot=1 pix=%h", cap_plot[2], cap_pix[2], {8'd11, 8'd20, 3'd7}); else pass_cnt++;
        plots = 0; fd = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_plot[k] === 1'b1) plots++;
            if (cap_done[k] === 1'b1 && fd < 0) fd = k;
        end
        total_cnt++; if (plots !== 250) $display("FAIL draw_plot_count: got %0d want 250", plots); else pass_cnt++;
        total_cnt++; if (fd !== 251) $display("FAIL draw_done_cycle: got %0d want 251", fd); else pass_cnt++;
        total_cnt++; if (cap_busy[251] !== 1'b0 || cap_busy[252] !== 1'b0)
            $display("FAIL draw_busy_after: got %b%b want 00", cap_busy[251], cap_busy[252]); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_busy[k] !== (k <= exp_len) || cap_done[k] !== (k == exp_len + 1) ||
                cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL draw_model: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_erase();
        logic [79:0] xs, ys;
        int bad, first, plots;
        xs = rand_coords(0, 200); ys = rand_coords(0, 200);
        build_model(1'b1, 10'h000, xs, ys);
        run_pass(1'b1, 10'h000, xs, ys, 1'b0, 0, 0);
        plots = 0;
        for (int k = 1; k <= WIN; k++) if (cap_plot[k] === 1'b1 && cap_pix[k][2:0] === 3'd0) plots++;
        total_cnt++; if (plots !== 250) $display("FAIL erase_bg_plots: got %0d want 250", plots); else pass_cnt++;
        total_cnt++; if (cap_done[251] !== 1'b1) $display("FAIL erase_done: got %b want 1", cap_done[251]); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_busy[k] !== (k <= exp_len) || cap_done[k] !== (k == exp_len + 1) ||
                cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL erase_model: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_visible_one();
        logic [79:0] xs, ys;
        int bad, first, plots, fd, want_fd;
        xs = rand_coords(0, 200); ys = rand_coords(0, 200);
        want_fd = SKIP ? 35 : 251;
        build_model(1'b0, 10'b0000000001, xs, ys);
        run_pass(1'b0, 10'b0000000001, xs, ys, 1'b0, 0, 0);
        plots = 0; fd = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_plot[k] === 1'b1) plots++;
            if (cap_done[k] === 1'b1 && fd < 0) fd = k;
        end
        total_cnt++; if (plots !== 25) $display("FAIL vis1_plot_count: got %0d want 25", plots); else pass_cnt++;
        total_cnt++; if (fd !== want_fd) $display("FAIL vis1_done_cycle: got %0d want %0d", fd, want_fd); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_busy[k] !== (k <= exp_len) || cap_done[k] !== (k == exp_len + 1) ||
                cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL vis1_model: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_clip();
        logic [79:0] xs, ys;
        int bad, first, plots;
        xs = rand_coords(0, 200); ys = rand_coords(0, 200);
        xs[7:0] = 8'd254; ys[7:0] = 8'd253;
        build_model(1'b0, 10'h3FF, xs, ys);
        run_pass(1'b0, 10'h3FF, xs, ys, 1'b0, 0, 0);
        plots = 0;
        for (int k = 1; k <= 25; k++) if (cap_plot[k] === 1'b1) plots++;
        total_cnt++; if (plots !== 6) $display("FAIL clip_plot_count: got %0d want 6", plots); else pass_cnt++;
        total_cnt++; if (cap_plot[7] !== 1'b1 || cap_pix[7][18:3] !== {8'd255, 8'd254})
            $display("FAIL clip_corner: got plot=%b xy=%h want plot=1 xy=%h", cap_plot[7], cap_pix[7][18:3], {8'd255, 8'd254}); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_busy[k] !== (k <= exp_len) || cap_done[k] !== (k == exp_len + 1) ||
                cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL clip_model: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [79:0] xs, ys;
        logic [9:0] vs;
        logic o;
        int bad, first;
        for (int t = 0; t < 6; t++) begin
            xs = rand_coords(0, 255); ys = rand_coords(0, 255);
            vs = 10'($urandom); o = 1'($urandom);
            build_model(o, vs, xs, ys);
            run_pass(o, vs, xs, ys, 1'b0, 0, 0);
            bad = 0; first = -1;
            for (int k = 1; k <= WIN; k++) begin
                if (cap_busy[k] !== (k <= exp_len) || cap_done[k] !== (k == exp_len + 1) ||
                    cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                    bad++; if (first < 0) first = k;
                end
            end
            total_cnt++; if (bad !== 0) $display("FAIL random_model_%0d: got %0d bad cycles (first %0d) want 0", t, bad, first); else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        logic [79:0] xs, ys;
        int bad, first, dones;
        xs = rand_coords(0, 255); ys = rand_coords(0, 255);
        build_model(1'b0, 10'h3FF, xs, ys);
        run_pass(1'b0, 10'h3FF, xs, ys, 1'b0, 100, 0);
        dones = 0;
        for (int k = 1; k <= WIN; k++) if (cap_done[k] === 1'b1) dones++;
        total_cnt++; if (dones !== 1) $display("FAIL ignore_done_count: got %0d want 1", dones); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = 1; k <= WIN; k++) begin
            if (cap_busy[k] !== (k <= exp_len) || cap_done[k] !== (k == exp_len + 1) ||
                cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL ignore_model: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [79:0] xs, ys;
        int bad, first, late;
        xs = rand_coords(0, 255); ys = rand_coords(0, 255);
        build_model(1'b0, 10'h3FF, xs, ys);
        run_pass(1'b0, 10'h3FF, xs, ys, 1'b0, 0, 50);
        total_cnt++; if ({cap_busy[51], cap_plot[51], cap_done[51]} !== 3'b000)
            $display("FAIL rst_mid_flags: got %b%b%b want 000", cap_busy[51], cap_plot[51], cap_done[51]); else pass_cnt++;
        total_cnt++; if (cap_pix[51] !== 19'd0) $display("FAIL rst_mid_pixel: got %h want 0", cap_pix[51]); else pass_cnt++;
        late = 0;
        for (int k = 51; k <= WIN; k++) if (cap_done[k] === 1'b1 || cap_busy[k] === 1'b1) late++;
        total_cnt++; if (late !== 0) $display("FAIL rst_mid_no_done: got %0d busy/done cycles want 0", late); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = 1; k < 50; k++) begin
            if (cap_busy[k] !== 1'b1 || cap_plot[k] !== exp_plot[k] || (exp_plot[k] && cap_pix[k] !== exp_pix[k])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL rst_mid_prefix: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [79:0] xs, ys;
        int bad, first, l1, guard;
        xs = rand_coords(0, 255); ys = rand_coords(0, 255);
        build_model(1'b0, 10'h3FF, xs, ys);
        l1 = exp_len;
        run_pass(1'b0, 10'h3FF, xs, ys, 1'b1, 0, 0);
        total_cnt++; if (cap_done[l1+1] !== 1'b1 || cap_busy[l1+1] !== 1'b0)
            $display("FAIL b2b_done: got done=%b busy=%b want done=1 busy=0", cap_done[l1+1], cap_busy[l1+1]); else pass_cnt++;
        build_model(live_op, live_vis, live_x, live_y);
        total_cnt++; if (cap_busy[l1+2] !== 1'b1 || cap_plot[l1+2] !== exp_plot[1] ||
                         (exp_plot[1] && cap_pix[l1+2] !== exp_pix[1]))
            $display("FAIL b2b_first_pixel: got busy=%b plot=%b pix=%h want busy=1 plot=%b pix=%h",
                     cap_busy[l1+2], cap_plot[l1+2], cap_pix[l1+2], exp_plot[1], exp_pix[1]); else pass_cnt++;
        bad = 0; first = -1;
        for (int k = l1 + 2; k <= WIN; k++) begin
            if (cap_plot[k] !== exp_plot[k-l1-1] || (exp_plot[k-l1-1] && cap_pix[k] !== exp_pix[k-l1-1])) begin
                bad++; if (first < 0) first = k;
            end
        end
        total_cnt++; if (bad !== 0) $display("FAIL b2b_model: got %0d bad cycles (first %0d) want 0", bad, first); else pass_cnt++;
        guard = 0;
        while (busy === 1'b1 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        total_cnt++; if (guard >= 600) $display("FAIL b2b_drain: got busy after %0d cycles want idle", guard); else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_draw_fixed();
        test_erase();
        test_visible_one();
        test_clip();
        test_random();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
